// File: rtl/div512_by256_pkg.sv
// Shared constants and state encoding for the 512/256 restoring divider.
package div512_by256_pkg;

  localparam int unsigned XW = 512;
  localparam int unsigned MW = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // secp256k1 group order n and field prime p
  localparam logic [MW-1:0] SECP256K1_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [MW-1:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step
  import div512_by256_pkg::*;
(
  input  logic [MW:0]   r_in,
  input  logic          bit_in,
  input  logic [MW-1:0] m,
  output logic [MW:0]   r_out,
  output logic          q_bit
);

  logic [MW:0] r_sh;

  // r_in[MW] is zero at every step boundary; folding it into the compare keeps the step safe regardless
  always_comb begin
    r_sh  = {r_in[MW-1:0], bit_in};
    q_bit = r_in[MW] | (r_sh >= {1'b0, m});
    r_out = q_bit ? (r_sh - {1'b0, m}) : r_sh;
  end

endmodule

// File: rtl/div512_by256.sv
// Sequential restoring divider X[511:0] / M[255:0], BPC quotient bits per clock.
module div512_by256
  import div512_by256_pkg::*;
#(
  parameter int unsigned BPC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] X,
  input  logic [MW-1:0] M,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] Q,
  output logic [MW-1:0] R,
  output logic          div_by_zero
);

  localparam int unsigned STEPS = XW / BPC;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t        state, state_d;
  logic          start_q;
  logic          launch_c;
  logic          last_c;
  logic [CW-1:0] count;
  logic [XW-1:0] xs;
  logic [XW-1:0] q_acc;
  logic [MW-1:0] m_r;
  logic [MW:0]   r_q;
  logic          dz_r;
  logic [MW:0]   r_chain [BPC+1];
  logic [BPC-1:0] q_bits;

  assign r_chain[0] = r_q;

  // BPC chained steps per clock, dividend MSB first; first step yields the group's top quotient bit
  for (genvar j = 0; j < BPC; j++) begin : g_step
    div_step u_step (
      .r_in  (r_chain[j]),
      .bit_in(xs[XW-1-j]),
      .m     (m_r),
      .r_out (r_chain[j+1]),
      .q_bit (q_bits[BPC-1-j])
    );
  end

  // Next-state logic; launch only on a fresh rising start while idle
  always_comb begin
    state_d  = state;
    launch_c = start & ~start_q & (state == ST_IDLE);
    last_c   = (count == CW'(STEPS - 1));
    unique case (state)
      ST_IDLE: if (launch_c) state_d = (M == '0) ? ST_FIN : ST_DIV;
      ST_DIV:  if (last_c) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Datapath and output registers; Q/R only update in FIN so they hold through the next division
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      count       <= '0;
      xs          <= '0;
      q_acc       <= '0;
      m_r         <= '0;
      r_q         <= '0;
      dz_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      start_q <= start;
      busy    <= (state_d != ST_IDLE);
      done    <= (state == ST_FIN);
      if (launch_c) begin
        xs    <= X;
        m_r   <= M;
        r_q   <= '0;
        q_acc <= '0;
        count <= '0;
        dz_r  <= (M == '0);
      end else if (state == ST_DIV) begin
        xs    <= xs << BPC;
        r_q   <= r_chain[BPC];
        q_acc <= {q_acc[XW-BPC-1:0], q_bits};
        count <= count + CW'(1);
      end
      if (state == ST_FIN) begin
        div_by_zero <= dz_r;
        Q           <= dz_r ? '1 : q_acc;
        R           <= dz_r ? xs[MW-1:0] : r_q[MW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_div512_by256.sv
// Self-checking bench: four divider instances (BPC=2,1,4,8) driven in lockstep.
module tb_div512_by256;
  import div512_by256_pkg::*;

  localparam int NI   = 4;
  localparam int NMAX = 516;

  function automatic int unsigned bpc_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [XW-1:0]  dx;
  logic [MW-1:0]  dm;
  logic           busy [NI];
  logic           done [NI];
  logic           dz   [NI];
  logic [XW-1:0]  q    [NI];
  logic [MW-1:0]  r    [NI];

  logic [XW-1:0]  prev_q [NI];
  logic [MW-1:0]  prev_r [NI];
  logic           prev_z [NI];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    div512_by256 #(.BPC(bpc_of(g))) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .X          (dx),
      .M          (dm),
      .busy       (busy[g]),
      .done       (done[g]),
      .Q          (q[g]),
      .R          (r[g]),
      .div_by_zero(dz[g])
    );
  end

  task automatic clear_prev();
    for (int i = 0; i < NI; i++) begin
      prev_q[i] = '0;
      prev_r[i] = '0;
      prev_z[i] = 1'b0;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      nchk++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || dz[i] !== 1'b0 || q[i] !== '0 || r[i] !== '0) begin
        nerr++;
        $display("FAIL %s inst%0d busy=%b done=%b dz=%b Qz=%b Rz=%b required all zero",
                 tag, i, busy[i], done[i], dz[i], (q[i] == '0), (r[i] == '0));
      end
    end
  endtask

  // Launch one division and check every instance cycle by cycle against the expected timeline
  task automatic run_op(input string tag, input logic [XW-1:0] x, input logic [MW-1:0] m,
                        input logic [XW-1:0] eq, input logic [MW-1:0] er, input logic ez,
                        input bit hold, input bit pulse);
    int unsigned lat;
    logic ebusy, edone, ez_x;
    logic [XW-1:0] eq_x;
    logic [MW-1:0] er_x;
    @(negedge clk);
    dx = x; dm = m; start = 1'b1;
    @(posedge clk);
    #1 start = hold;
    for (int k = 0; k <= NMAX; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      if (pulse && !hold) begin
        if (k == 40) start = 1'b1;
        else if (k == 41) start = 1'b0;
      end
      for (int i = 0; i < NI; i++) begin
        lat = ez ? 1 : (XW / bpc_of(i)) + 1;
        if (k < lat) begin
          ebusy = 1'b1; edone = 1'b0; eq_x = prev_q[i]; er_x = prev_r[i]; ez_x = prev_z[i];
        end else begin
          ebusy = 1'b0; edone = (k == lat); eq_x = eq; er_x = er; ez_x = ez;
        end
        nchk++;
        if (busy[i] !== ebusy || done[i] !== edone) begin
          nerr++;
          $display("FAIL %s ctl inst%0d k=%0d busy=%b done=%b required busy=%b done=%b",
                   tag, i, k, busy[i], done[i], ebusy, edone);
        end
        nchk++;
        if (q[i] !== eq_x) begin
          nerr++;
          $display("FAIL %s Q inst%0d k=%0d got %h required %h", tag, i, k, q[i], eq_x);
        end
        nchk++;
        if (r[i] !== er_x || dz[i] !== ez_x) begin
          nerr++;
          $display("FAIL %s R inst%0d k=%0d got R=%h dz=%b required R=%h dz=%b",
                   tag, i, k, r[i], dz[i], er_x, ez_x);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      prev_q[i] = eq; prev_r[i] = er; prev_z[i] = ez;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dx = '0; dm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset_hold");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset_release");
    clear_prev();
  endtask

  task automatic test_product();
    logic [MW-1:0] a;
    logic [XW-1:0] x;
    a = 256'h123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0_123456789ABCDEF0;
    x = {256'b0, a} * {256'b0, SECP256K1_N};
    run_op("product", x, SECP256K1_N, {256'b0, a}, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_max();
    logic [XW-1:0] eq;
    eq = '0; eq[256] = 1'b1; eq[0] = 1'b1;
    run_op("max", '1, '1, eq, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_near_n();
    logic [XW-1:0] x;
    x = {256'b0, SECP256K1_N} * 512'd3 + 512'd5;
    run_op("three_n", x, SECP256K1_N, 512'd3, 256'd5, 1'b0, 1'b0, 1'b0);
    run_op("x_lt_m", 512'd5, SECP256K1_N, '0, 256'd5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_div();
    run_op("zero_div", 512'hDEAD_BEEF, '0, '1, 256'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
  endtask

  // Abort mid-division: outputs clear, no done afterwards, next launch still correct
  task automatic test_reset_mid();
    logic [XW-1:0] x;
    x = {256'b0, SECP256K1_P} * 512'd7 + 512'd11;
    @(negedge clk);
    dx = x; dm = SECP256K1_P; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("mid_reset");
    for (int k = 0; k < 520; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        nchk++;
        if (done[i] !== 1'b0 || busy[i] !== 1'b0) begin
          nerr++;
          $display("FAIL post_reset inst%0d k=%0d busy=%b done=%b required 0 0", i, k, busy[i], done[i]);
        end
      end
    end
    clear_prev();
    x = {256'b0, SECP256K1_N} * 512'd3 + 512'd5;
    run_op("after_reset", x, SECP256K1_N, 512'd3, 256'd5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_hold();
    run_op("hold_start", 512'd1000, 256'd7, 512'd142, 256'd6, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_pulse_busy();
    logic [XW-1:0] x;
    x = {256'b0, SECP256K1_P} * 512'd9 + 512'd2;
    run_op("pulse_busy", x, SECP256K1_P, 512'd9, 256'd2, 1'b0, 1'b0, 1'b1);
  endtask

  // Random operands checked against plain big-integer division
  task automatic test_random();
    logic [XW-1:0] x, eq, rem;
    logic [MW-1:0] m;
    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 16; w++) x[w*32 +: 32] = $urandom();
      for (int w = 0; w < 8; w++)  m[w*32 +: 32] = $urandom();
      case (n % 3)
        0: m = {224'b0, m[31:0]};
        1: x = {288'b0, x[223:0]};
        default: m[MW-1] = 1'b1;
      endcase
      if (m == '0) m = 256'd1;
      eq  = x / {256'b0, m};
      rem = x % {256'b0, m};
      run_op("random", x, m, eq, rem[MW-1:0], 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_product();
    test_max();
    test_near_n();
    test_zero_div();
    test_reset_mid();
    test_start_hold();
    test_pulse_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
